mem_arbiter: RTL and testbench

Two-port memory arbiter between the CPU's instruction-fetch and data-access paths and the single shared memory request/response bus at the top level. Selects one requester per request handshake and forwards its request unmodified. Records the source of every read in an in-order tag FIFO, and steers each response beat back to the requester that issued the read. Request and response paths are combinational muxes; the grant lock, the arbitration pointer and the tag FIFO are sequential.

---
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bus bundle shared by the requesters and the memory side.
// Ports: req_addr/we/data/be + req_valid/req_ready, resp_data + resp_valid/resp_ready.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic                    req_we;
   logic [DATA_WIDTH-1:0]   req_data;
   logic [DATA_WIDTH/8-1:0] req_be;
   logic                    req_valid;
   logic                    req_ready;
   logic [DATA_WIDTH-1:0]   resp_data;
   logic                    resp_valid;
   logic                    resp_ready;

   modport master (
      output req_addr, req_we, req_data, req_be, req_valid, resp_ready,
      input  req_ready, resp_data, resp_valid
   );

   modport slave (
      input  req_addr, req_we, req_data, req_be, req_valid, resp_ready,
      output req_ready, resp_data, resp_valid
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: m0 (fetch) and m1 (data) share one memory bus.
// Ports: clk, rst (async, active-high), m0/m1 requester slave ports,
// mem downstream master port. Reads are tagged in an in-order FIFO so
// each response beat is steered back to the issuing requester.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m1 has
// fixed priority over m0.
module mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  m0,
   mem_arbiter_if.slave  m1,
   mem_arbiter_if.master mem
);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   typedef enum logic {UNLOCKED, LOCKED} lock_t;

   lock_t                      lock_state;
   logic                       lock_idx;
   logic [MAX_OUTSTANDING-1:0] tags;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              count;

   logic full;
   logic empty;
   logic sel;
   logic sel_valid;
   logic sel_we;
   logic req_fire;
   logic resp_fire;
   logic push;
   logic head;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr;
`endif

   assign full  = (count == CW'(MAX_OUTSTANDING));
   assign empty = (count == '0);

   // A stalled grant stays with its port until it transfers.
   always_comb begin
      sel = 1'b0;
      if (lock_state == LOCKED) begin
         sel = lock_idx;
      end else if (m0.req_valid && m1.req_valid) begin
`ifdef MEM_ARB_RR_EN
         sel = rr_ptr;
`else
         sel = 1'b1;
`endif
      end else begin
         sel = m1.req_valid;
      end
   end

   assign sel_valid = sel ? m1.req_valid : m0.req_valid;
   assign sel_we    = sel ? m1.req_we    : m0.req_we;

   assign mem.req_addr  = sel ? m1.req_addr : m0.req_addr;
   assign mem.req_we    = sel_we;
   assign mem.req_data  = sel ? m1.req_data : m0.req_data;
   assign mem.req_be    = sel ? m1.req_be   : m0.req_be;
   assign mem.req_valid = sel_valid && !full && !rst;

   assign m0.req_ready = !sel && mem.req_ready && !full && !rst;
   assign m1.req_ready =  sel && mem.req_ready && !full && !rst;

   assign req_fire = mem.req_valid && mem.req_ready;
   assign push     = req_fire && !sel_we;

   assign head = tags[rd_ptr];

   assign m0.resp_data  = mem.resp_data;
   assign m1.resp_data  = mem.resp_data;
   assign m0.resp_valid = mem.resp_valid && !head && !empty && !rst;
   assign m1.resp_valid = mem.resp_valid &&  head && !empty && !rst;

   // Nothing outstanding: leave any stray response unacknowledged.
   assign mem.resp_ready = !empty && !rst &&
                           (head ? m1.resp_ready : m0.resp_ready);

   assign resp_fire = mem.resp_valid && mem.resp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_state <= UNLOCKED;
         lock_idx   <= 1'b0;
         tags       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         if (req_fire) begin
            lock_state <= UNLOCKED;
         end else if (mem.req_valid) begin
            lock_state <= LOCKED;
            lock_idx   <= sel;
         end

         if (push) begin
            tags[wr_ptr] <= sel;
            wr_ptr       <= wr_ptr + PW'(1);
         end

         if (resp_fire) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         case ({push, resp_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef MEM_ARB_RR_EN
   // Preference passes to the port that just lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (req_fire) begin
         rr_ptr <= !sel;
      end
   end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_mem_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

   mem_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .m0(m0_bus),
      .m1(m1_bus),
      .mem(mem_bus)
   );

   int tests  = 0;
   int failed = 0;

   // Reference model state: outstanding read owners, stalled grant, preference.
   int q[$];
   int lk   = -1;
   int pref = 0;
   bit acc[2];

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      bit v[2];
      bit we[2];
      bit rr[2];
      int g;
      int h;
      bit fullm;
      bit ev;
      bit pop;
      logic [127:0] pay_exp;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      if (rst) begin
         chk("rst_mem_req_valid", mem_bus.req_valid, 0);
         chk("rst_mem_resp_ready", mem_bus.resp_ready, 0);
         chk("rst_req_ready", {m0_bus.req_ready, m1_bus.req_ready}, 0);
         chk("rst_resp_valid", {m0_bus.resp_valid, m1_bus.resp_valid}, 0);
         q.delete();
         lk   = -1;
         pref = 0;
      end else begin
         v[0]  = m0_bus.req_valid;
         v[1]  = m1_bus.req_valid;
         we[0] = m0_bus.req_we;
         we[1] = m1_bus.req_we;
         rr[0] = m0_bus.resp_ready;
         rr[1] = m1_bus.resp_ready;
         fullm = (q.size() == MAXO);
         if (lk >= 0) g = lk;
         else if (v[0] && v[1]) g = RR ? pref : 1;
         else g = v[1] ? 1 : 0;
         ev = v[g] && !fullm;
         chk("mem_req_valid", mem_bus.req_valid, ev);
         if (ev) begin
            pay_exp = (g == 1) ?
               {m1_bus.req_addr, m1_bus.req_we, m1_bus.req_data, m1_bus.req_be} :
               {m0_bus.req_addr, m0_bus.req_we, m0_bus.req_data, m0_bus.req_be};
            chk("mem_req_payload",
                {mem_bus.req_addr, mem_bus.req_we, mem_bus.req_data, mem_bus.req_be},
                pay_exp);
         end
         if (v[0])
            chk("m0_req_ready", m0_bus.req_ready,
                (g == 0) && !fullm && mem_bus.req_ready);
         if (v[1])
            chk("m1_req_ready", m1_bus.req_ready,
                (g == 1) && !fullm && mem_bus.req_ready);
         chk("resp_data", {m0_bus.resp_data, m1_bus.resp_data},
             {mem_bus.resp_data, mem_bus.resp_data});
         pop = 1'b0;
         if (q.size() == 0) begin
            chk("empty_resp_ready", mem_bus.resp_ready, 0);
            chk("empty_resp_valid", {m0_bus.resp_valid, m1_bus.resp_valid}, 0);
         end else begin
            h = q[0];
            chk("m0_resp_valid", m0_bus.resp_valid, (h == 0) && mem_bus.resp_valid);
            chk("m1_resp_valid", m1_bus.resp_valid, (h == 1) && mem_bus.resp_valid);
            chk("mem_resp_ready", mem_bus.resp_ready, rr[h]);
            pop = mem_bus.resp_valid && rr[h];
         end
         if (pop) void'(q.pop_front());
         if (ev && mem_bus.req_ready) begin
            acc[g] = 1'b1;
            if (!we[g]) q.push_back(g);
            pref = 1 - g;
            lk   = -1;
         end else if (ev) begin
            lk = g;
         end
      end
   end

   task automatic next;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m0_bus.req_valid  = 0; m0_bus.req_we = 0; m0_bus.req_addr = '0;
      m0_bus.req_data   = '0; m0_bus.req_be = '0; m0_bus.resp_ready = 0;
      m1_bus.req_valid  = 0; m1_bus.req_we = 0; m1_bus.req_addr = '0;
      m1_bus.req_data   = '0; m1_bus.req_be = '0; m1_bus.resp_ready = 0;
      mem_bus.req_ready = 0; mem_bus.resp_valid = 0; mem_bus.resp_data = '0;
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b1;
      next();
      rst = 1'b0;
   endtask

   task automatic rand_req(input int n);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] b;
      bit w;
      bit v;
      a = $urandom;
      d = $urandom;
      b = BW'($urandom);
      w = $urandom_range(0, 2) == 0;
      v = $urandom_range(0, 2) != 0;
      if (n == 0) begin
         if (!(m0_bus.req_valid && !acc[0])) begin
            m0_bus.req_valid = v; m0_bus.req_addr = a;
            m0_bus.req_data = d; m0_bus.req_be = b; m0_bus.req_we = w;
         end
      end else begin
         if (!(m1_bus.req_valid && !acc[1])) begin
            m1_bus.req_valid = v; m1_bus.req_addr = a;
            m1_bus.req_data = d; m1_bus.req_be = b; m1_bus.req_we = w;
         end
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("init_mem_req_valid", mem_bus.req_valid, 0);
      chk("init_mem_resp_ready", mem_bus.resp_ready, 0);
      next();
      rst = 1'b0;

      // Single fetch read and its response.
      m0_bus.req_valid = 1; m0_bus.req_addr = 32'h8000_0000;
      mem_bus.req_ready = 1;
      @(negedge clk);
      chk("t1_addr", mem_bus.req_addr, 32'h8000_0000);
      chk("t1_m0_ready", m0_bus.req_ready, 1);
      next();
      m0_bus.req_valid = 0;
      mem_bus.resp_valid = 1; mem_bus.resp_data = 32'h0000_0013;
      m0_bus.resp_ready = 1;
      @(negedge clk);
      chk("t1_m0_resp_valid", m0_bus.resp_valid, 1);
      chk("t1_m1_resp_valid", m1_bus.resp_valid, 0);
      chk("t1_m0_resp_data", m0_bus.resp_data, 32'h13);
      next();
      @(negedge clk);
      chk("t1_empty_after", mem_bus.resp_ready, 0);
      next();

      // Both requesters valid every cycle (writes, so no FIFO growth).
      do_reset();
      m0_bus.req_valid = 1; m0_bus.req_we = 1;
      m1_bus.req_valid = 1; m1_bus.req_we = 1;
      mem_bus.req_ready = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t2_m0_grant", m0_bus.req_ready, RR ? (i % 2 == 0) : 1'b0);
         chk("t2_m1_grant", m1_bus.req_ready, RR ? (i % 2 == 1) : 1'b1);
         next();
      end

      // Stalled grant is not preempted by the other port.
      do_reset();
      m0_bus.req_valid = 1; m0_bus.req_addr = 32'h1000;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            m1_bus.req_valid = 1; m1_bus.req_addr = 32'h2000;
         end
         @(negedge clk);
         chk("t3_lock_addr", mem_bus.req_addr, 32'h1000);
         chk("t3_lock_m0_ready", m0_bus.req_ready, 0);
         next();
      end
      mem_bus.req_ready = 1;
      @(negedge clk);
      chk("t3_m0_xfer", m0_bus.req_ready, 1);
      chk("t3_m1_wait", m1_bus.req_ready, 0);
      next();
      m0_bus.req_valid = 0;
      @(negedge clk);
      chk("t3_m1_xfer", m1_bus.req_ready, 1);
      chk("t3_m1_addr", mem_bus.req_addr, 32'h2000);
      next();

      // Fill the tag FIFO, then free one slot.
      do_reset();
      mem_bus.req_ready = 1;
      m0_bus.req_valid = 1;
      for (int i = 0; i < 4; i++) begin
         m0_bus.req_addr = 32'h100 + 32'(i * 4);
         @(negedge clk);
         chk("t4_fill_ready", m0_bus.req_ready, 1);
         next();
      end
      m0_bus.req_addr = 32'h200;
      @(negedge clk);
      chk("t4_full_valid", mem_bus.req_valid, 0);
      chk("t4_full_ready", m0_bus.req_ready, 0);
      next();
      mem_bus.resp_valid = 1; m0_bus.resp_ready = 1;
      @(negedge clk);
      chk("t4_pop_resp", m0_bus.resp_valid, 1);
      chk("t4_full_during_pop", mem_bus.req_valid, 0);
      next();
      mem_bus.resp_valid = 0;
      @(negedge clk);
      chk("t4_accept_5th", m0_bus.req_ready, 1);
      next();
      m0_bus.req_valid = 0;
      mem_bus.resp_valid = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_drain", m0_bus.resp_valid, 1);
         next();
      end
      idle();

      // Interleaved reads/writes, responses routed 0,1,0 with a stall.
      do_reset();
      mem_bus.req_ready = 1;
      for (int i = 0; i < 5; i++) begin
         int port;
         bit w;
         port = (i == 1 || i == 2) ? 1 : 0;
         w = (i == 1 || i == 3);
         m0_bus.req_valid = (port == 0); m0_bus.req_we = w;
         m1_bus.req_valid = (port == 1); m1_bus.req_we = w;
         @(negedge clk);
         chk("t5_issue", port ? m1_bus.req_ready : m0_bus.req_ready, 1);
         next();
      end
      idle();
      mem_bus.resp_valid = 1; mem_bus.resp_data = 32'hA;
      m0_bus.resp_ready = 1; m1_bus.resp_ready = 1;
      @(negedge clk);
      chk("t5_r0_m0", m0_bus.resp_valid, 1);
      chk("t5_r0_m1", m1_bus.resp_valid, 0);
      next();
      m1_bus.resp_ready = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t5_stall_valid", m1_bus.resp_valid, 1);
         chk("t5_stall_ready", mem_bus.resp_ready, 0);
         next();
      end
      m1_bus.resp_ready = 1;
      @(negedge clk);
      chk("t5_r1_m1", m1_bus.resp_valid, 1);
      chk("t5_r1_ready", mem_bus.resp_ready, 1);
      next();
      @(negedge clk);
      chk("t5_r2_m0", m0_bus.resp_valid, 1);
      chk("t5_r2_m1", m1_bus.resp_valid, 0);
      next();
      @(negedge clk);
      chk("t5_no_fourth", mem_bus.resp_ready, 0);
      next();
      idle();

      // Reset with tags outstanding and a held grant.
      do_reset();
      mem_bus.req_ready = 1;
      m0_bus.req_valid = 1;
      next();
      next();
      m0_bus.req_valid = 0;
      m1_bus.req_valid = 1;
      mem_bus.req_ready = 0;
      mem_bus.resp_valid = 1; m0_bus.resp_ready = 0;
      @(negedge clk);
      chk("t6_locked_valid", mem_bus.req_valid, 1);
      next();
      rst = 1'b1;
      #1;
      chk("t6_rst_req_valid", mem_bus.req_valid, 0);
      chk("t6_rst_resp_ready", mem_bus.resp_ready, 0);
      chk("t6_rst_req_ready", {m0_bus.req_ready, m1_bus.req_ready}, 0);
      chk("t6_rst_resp_valid", {m0_bus.resp_valid, m1_bus.resp_valid}, 0);
      next();
      rst = 1'b0;
      idle();
      mem_bus.resp_valid = 1; m0_bus.resp_ready = 1; m1_bus.resp_ready = 1;
      @(negedge clk);
      chk("t6_after_rst_resp_ready", mem_bus.resp_ready, 0);
      next();
      idle();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rand_req(0);
         rand_req(1);
         mem_bus.req_ready  = $urandom_range(0, 3) != 0;
         mem_bus.resp_valid = $urandom_range(0, 1);
         mem_bus.resp_data  = $urandom;
         m0_bus.resp_ready  = $urandom_range(0, 3) != 0;
         m1_bus.resp_ready  = $urandom_range(0, 3) != 0;
         next();
      end
      idle();
      next();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
